// File: rtl/ten_eth_tx_hdr_ins.sv
// Prepends a 14-byte Ethernet header to a 64-bit payload stream, realigns the payload
// by 6 bytes behind it, and zero-pads short frames up to P_MIN_LEN bytes (FCS excluded).
module ten_eth_tx_hdr_ins #(
  parameter int P_MIN_LEN = 60
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [47:0] i_dst_mac,
  input  logic [47:0] i_src_mac,
  input  logic [15:0] i_eth_type,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        o_busy,
  output logic [31:0] o_frame_cnt,
  output logic [2:0]  o_dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR0    = 3'd1;
  localparam logic [2:0] S_HDR1    = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_PAD     = 3'd5;

  logic [2:0]  state_q, state_d;
  logic [47:0] resid_q, resid_d;
  logic [2:0]  rcnt_q, rcnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [63:0] m_tdata_q, m_tdata_d;
  logic [7:0]  m_tkeep_q, m_tkeep_d;
  logic        m_tlast_q, m_tlast_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic [31:0] frame_cnt_q, frame_cnt_d;

  // Both streams transfer a beat on a rising edge where valid and ready are both high;
  // a source holds its beat unchanged until that edge, and ready never depends on a
  // future transfer. The output register may take a new beat when it is empty or
  // draining, unless it holds the final beat of a frame (the next frame waits for IDLE).
  logic fin_pend, out_free, can_load;
  assign fin_pend      = m_tvalid_q & m_tlast_q;
  assign out_free      = m_axis_tready | ~m_tvalid_q;
  assign can_load      = out_free & ~fin_pend;
  assign s_axis_tready = ((state_q == S_HDR1) | (state_q == S_PAYLOAD)) & can_load;

  // Byte count of the incoming beat: run of ones from keep bit 0, minimum 1 on tlast.
  logic [3:0] lead_ones, in_cnt;
  always_comb begin
    lead_ones = 4'd0;
    for (int i = 7; i >= 0; i--) lead_ones = s_axis_tkeep[i] ? lead_ones + 4'd1 : 4'd0;
    if (!s_axis_tlast)          in_cnt = 4'd8;
    else if (lead_ones == 4'd0) in_cnt = 4'd1;
    else                        in_cnt = lead_ones;
  end

  // Candidate data beat: beat_bb valid bytes; beat_end marks the last payload byte.
  logic        beat_go, beat_end;
  logic [63:0] beat_raw, beat_data;
  logic [3:0]  beat_bb;
  always_comb begin
    beat_go  = 1'b0;
    beat_end = 1'b0;
    beat_raw = 64'd0;
    beat_bb  = 4'd8;
    case (state_q)
      S_HDR1, S_PAYLOAD: begin
        beat_go  = s_axis_tvalid & s_axis_tready;
        beat_raw = {s_axis_tdata[15:0], resid_q};
        beat_bb  = (in_cnt == 4'd1) ? 4'd7 : 4'd8;
        beat_end = s_axis_tlast & (in_cnt <= 4'd2);
      end
      S_FLUSH: begin
        beat_go  = can_load;
        beat_raw = {16'd0, resid_q};
        beat_bb  = {1'b0, rcnt_q};
        beat_end = 1'b1;
      end
      S_PAD: begin
        beat_go  = can_load;
        beat_bb  = 4'd0;
        beat_end = 1'b1;
      end
      default: ;
    endcase
  end

  // Frame end = max(bytes so far + beat bytes, P_MIN_LEN); final when it lands in this beat.
  logic [16:0] sum17, end_len, rem17, cnt_plus8;
  logic        is_final;
  logic [7:0]  keep_out;
  always_comb begin
    sum17     = {1'b0, byte_cnt_q} + 17'(beat_bb);
    end_len   = (sum17 > 17'(P_MIN_LEN)) ? sum17 : 17'(P_MIN_LEN);
    rem17     = end_len - {1'b0, byte_cnt_q};
    is_final  = beat_end & (rem17 <= 17'd8);
    keep_out  = is_final ? (8'hFF >> (4'd8 - rem17[3:0])) : 8'hFF;
    cnt_plus8 = {1'b0, byte_cnt_q} + 17'd8;
    for (int i = 0; i < 8; i++)
      beat_data[8*i +: 8] = (4'(i) < beat_bb) ? beat_raw[8*i +: 8] : 8'h00;
  end

  always_comb begin
    state_d     = state_q;
    resid_d     = resid_q;
    rcnt_d      = rcnt_q;
    byte_cnt_d  = byte_cnt_q;
    m_tdata_d   = m_tdata_q;
    m_tkeep_d   = m_tkeep_q;
    m_tlast_d   = m_tlast_q;
    m_tvalid_d  = m_tvalid_q;
    frame_cnt_d = frame_cnt_q;

    if (m_tvalid_q & m_axis_tready) m_tvalid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (s_axis_tvalid) begin
          // Header bytes go out MSB first; src[31:0] and EtherType become the
          // "residual" that HDR1 places ahead of the first two payload bytes.
          m_tdata_d  = {i_src_mac[39:32], i_src_mac[47:40],
                        i_dst_mac[7:0], i_dst_mac[15:8], i_dst_mac[23:16],
                        i_dst_mac[31:24], i_dst_mac[39:32], i_dst_mac[47:40]};
          resid_d    = {i_eth_type[7:0], i_eth_type[15:8],
                        i_src_mac[7:0], i_src_mac[15:8], i_src_mac[23:16], i_src_mac[31:24]};
          m_tkeep_d  = 8'hFF;
          m_tlast_d  = 1'b0;
          m_tvalid_d = 1'b1;
          byte_cnt_d = 16'd8;
          state_d    = S_HDR0;
        end
      end
      S_HDR0: if (m_tvalid_q & m_axis_tready) state_d = S_HDR1;
      default: ;
    endcase

    if (beat_go) begin
      m_tdata_d  = beat_data;
      m_tkeep_d  = keep_out;
      m_tlast_d  = is_final;
      m_tvalid_d = 1'b1;
      if (!is_final) byte_cnt_d = cnt_plus8[16] ? 16'hFFFF : cnt_plus8[15:0];
      if ((state_q == S_HDR1) || (state_q == S_PAYLOAD)) begin
        resid_d = s_axis_tdata[63:16];
        rcnt_d  = 3'(in_cnt - 4'd2);
      end
      if (is_final)          state_d = state_q;
      else if (beat_end)     state_d = S_PAD;
      else if (s_axis_tlast) state_d = S_FLUSH;
      else                   state_d = S_PAYLOAD;
    end

    if (fin_pend & m_axis_tready) begin
      state_d     = S_IDLE;
      byte_cnt_d  = 16'd0;
      frame_cnt_d = frame_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= S_IDLE;
      resid_q     <= 48'd0;
      rcnt_q      <= 3'd0;
      byte_cnt_q  <= 16'd0;
      m_tdata_q   <= 64'd0;
      m_tkeep_q   <= 8'd0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      frame_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      resid_q     <= resid_d;
      rcnt_q      <= rcnt_d;
      byte_cnt_q  <= byte_cnt_d;
      m_tdata_q   <= m_tdata_d;
      m_tkeep_q   <= m_tkeep_d;
      m_tlast_q   <= m_tlast_d;
      m_tvalid_q  <= m_tvalid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tkeep  = m_tkeep_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tvalid = m_tvalid_q;
  assign o_busy        = (state_q != S_IDLE);
  assign o_frame_cnt   = frame_cnt_q;
  assign o_dbg_state   = state_q;

endmodule
